// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the weight-stationary systolic matrix-multiply engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int unsigned DEF_M          = 5;
    localparam int unsigned DEF_N          = 3;
    localparam int unsigned DEF_K          = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Width that holds N full-scale products without wrapping.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int unsigned elem_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Streaming W/X/Y valid-ready bundle between operand fetch, the engine and writeback.
interface systolic_mm_engine_if
    import systolic_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned K          = DEF_K,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, N)
);
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH*K-1:0]   w_data;
    logic                      x_valid;
    logic                      x_ready;
    logic [DATA_WIDTH*N-1:0]   x_data;
    logic                      y_valid;
    logic                      y_ready;
    logic [ACC_WIDTH*K-1:0]    y_data;
    logic                      y_last;

    modport master (
        output w_valid, w_data, x_valid, x_data, y_ready,
        input  w_ready, x_ready, y_valid, y_data, y_last
    );

    modport slave (
        input  w_valid, w_data, x_valid, x_data, y_ready,
        output w_ready, x_ready, y_valid, y_data, y_last
    );
endinterface

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, x pass-through, psum MAC and valid tag.
module systolic_pe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  v_in,
    input  logic [ACC_WIDTH-1:0]  psum_in,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  v_out,
    output logic [ACC_WIDTH-1:0]  psum_out
);
    logic [DATA_WIDTH-1:0] w_q;
    logic [ACC_WIDTH-1:0]  x_ext;
    logic [ACC_WIDTH-1:0]  w_ext;

    // Extend to full accumulator width so the product wraps modulo 2^ACC_WIDTH.
    always_comb begin
        x_ext = signed_mode ? ACC_WIDTH'($signed(x_in)) : ACC_WIDTH'(x_in);
        w_ext = signed_mode ? ACC_WIDTH'($signed(w_q))  : ACC_WIDTH'(w_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q      <= '0;
            x_out    <= '0;
            v_out    <= 1'b0;
            psum_out <= '0;
        end else begin
            if (w_load) begin
                w_q <= w_in;
            end
            if (en) begin
                x_out    <= x_in;
                v_out    <= v_in;
                psum_out <= psum_in + ACC_WIDTH'(x_ext * w_ext);
            end
        end
    end
endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing weight-stationary systolic engine: Y[MxK] = X[MxN] * W[NxK] per job.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int unsigned M          = DEF_M,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned K          = DEF_K,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, N)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic signed_mode,
    output logic busy,
    systolic_mm_engine_if.slave bus
);
    localparam int unsigned MCW = cnt_width(M);
    localparam int unsigned NCW = cnt_width(N);

    state_t         state;
    logic           smode;
    logic [NCW-1:0] wrow;
    logic [MCW-1:0] xcnt;
    logic [MCW-1:0] ycnt;
    logic           stall;
    logic           en;
    logic           w_hs;
    logic           x_hs;
    logic           y_hs;

    logic [DATA_WIDTH-1:0] xa [N][K+1];
    logic                  va [N][K+1];
    logic [ACC_WIDTH-1:0]  pa [N+1][K];
    logic [ACC_WIDTH-1:0]  yd [K];
    logic [ACC_WIDTH*K-1:0] yrow;
    logic                  unused_edge;

    // A held Y row freezes the whole pipeline so nothing is lost or reordered.
    assign stall       = bus.y_valid && !bus.y_ready;
    assign en          = !stall;
    assign bus.x_ready = (state == STREAM) && !stall;
    assign w_hs        = bus.w_valid && bus.w_ready;
    assign x_hs        = bus.x_valid && bus.x_ready;
    assign y_hs        = bus.y_valid && bus.y_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            smode       <= 1'b0;
            wrow        <= '0;
            xcnt        <= '0;
            bus.w_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= LOAD_W;
                    smode       <= signed_mode;
                    wrow        <= '0;
                    bus.w_ready <= 1'b1;
                    busy        <= 1'b1;
                end
                LOAD_W: if (w_hs) begin
                    if (wrow == NCW'(N - 1)) begin
                        wrow        <= '0;
                        bus.w_ready <= 1'b0;
                        state       <= STREAM;
                    end else begin
                        wrow <= wrow + NCW'(1);
                    end
                end
                STREAM: if (x_hs) begin
                    if (xcnt == MCW'(M - 1)) begin
                        xcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        xcnt <= xcnt + MCW'(1);
                    end
                end
                DRAIN: if (y_hs && bus.y_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input skew: element n rides n+1 registers, tagged with the handshake.
    for (genvar gn = 0; gn < N; gn++) begin : g_skew
        localparam int unsigned SL = gn + 1;
        localparam int unsigned SW = SL * DATA_WIDTH;
        logic [SW-1:0] sx;
        logic [SL-1:0] sv;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sx <= '0;
                sv <= '0;
            end else if (en) begin
                sx <= SW'({sx, bus.x_data[elem_lo(gn, DATA_WIDTH) +: DATA_WIDTH]});
                sv <= SL'({sv, x_hs});
            end
        end
        assign xa[gn][0] = sx[elem_lo(gn, DATA_WIDTH) +: DATA_WIDTH];
        assign va[gn][0] = sv[gn];
    end

    for (genvar gk = 0; gk < K; gk++) begin : g_top
        assign pa[0][gk] = '0;
    end

    for (genvar gn = 0; gn < N; gn++) begin : g_row
        for (genvar gk = 0; gk < K; gk++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .signed_mode(smode),
                .w_load     (w_hs && (wrow == NCW'(gn))),
                .w_in       (bus.w_data[elem_lo(gk, DATA_WIDTH) +: DATA_WIDTH]),
                .x_in       (xa[gn][gk]),
                .v_in       (va[gn][gk]),
                .psum_in    (pa[gn][gk]),
                .x_out      (xa[gn][gk+1]),
                .v_out      (va[gn][gk+1]),
                .psum_out   (pa[gn+1][gk])
            );
        end
    end

    // Output deskew: column k waits K-1-k cycles so the whole row lines up.
    for (genvar gk = 0; gk < K; gk++) begin : g_deskew
        localparam int unsigned D = K - 1 - gk;
        if (D == 0) begin : g_direct
            assign yd[gk] = pa[N][gk];
        end else begin : g_delay
            logic [D*ACC_WIDTH-1:0] dq;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dq <= '0;
                end else if (en) begin
                    dq <= (D*ACC_WIDTH)'({dq, pa[N][gk]});
                end
            end
            assign yd[gk] = dq[elem_lo(D - 1, ACC_WIDTH) +: ACC_WIDTH];
        end
    end

    always_comb begin
        yrow        = '0;
        unused_edge = 1'b0;
        for (int unsigned k = 0; k < K; k++) begin
            yrow[elem_lo(k, ACC_WIDTH) +: ACC_WIDTH] = yd[k];
        end
        for (int unsigned n = 0; n < N; n++) begin
            unused_edge = unused_edge ^ (^xa[n][K]) ^ va[n][K];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.y_valid <= 1'b0;
            bus.y_data  <= '0;
            bus.y_last  <= 1'b0;
            ycnt        <= '0;
        end else if (en) begin
            bus.y_valid <= va[N-1][K];
            bus.y_last  <= va[N-1][K] && (ycnt == MCW'(M - 1));
            if (va[N-1][K]) begin
                bus.y_data <= yrow;
                ycnt       <= (ycnt == MCW'(M - 1)) ? '0 : ycnt + MCW'(1);
            end
        end
    end
endmodule
